// File: rtl/axi_mem_slave_if.sv
// AXI4 channel bundle between a memory master and axi_mem_slave.
// Signal names match the flat io_memAXI_0_* ports so existing hookups map one to one.
interface axi_mem_slave_if #(
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);
  logic                  aw_valid;
  logic                  aw_ready;
  logic [63:0]           aw_addr;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;

  logic                  w_valid;
  logic                  w_ready;
  logic [63:0]           w_data;
  logic [7:0]            w_strb;
  logic                  w_last;

  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;
  logic [ID_WIDTH-1:0]   b_id;
  logic [USER_WIDTH-1:0] b_user;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [63:0]           ar_addr;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;

  logic                  r_valid;
  logic                  r_ready;
  logic [1:0]            r_resp;
  logic [63:0]           r_data;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic [USER_WIDTH-1:0] r_user;

  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp, b_id, b_user,
    input  b_ready,
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_resp, r_data, r_last, r_id, r_user,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp, b_id, b_user,
    output b_ready,
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_resp, r_data, r_last, r_id, r_user,
    output r_ready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: one outstanding transaction, 64-bit word array, FIXED/INCR/WRAP
// bursts, decode-error and sticky write-response reporting.
module axi_mem_slave #(
  parameter int          ID_WIDTH      = 4,
  parameter int          USER_WIDTH    = 1,
  parameter logic [63:0] BASE_ADDR     = 64'h8000_0000,
  parameter int          MEM_WORDS     = 4096,
  parameter string       MEM_INIT_FILE = ""
) (
  input logic            clock,
  input logic            reset,
  axi_mem_slave_if.slave axi
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WDATA, WRESP} state_e;

  state_e              state_q;
  logic [63:0]         addr_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [7:0]          len_q;
  logic [7:0]          cnt_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [1:0]          resp_q;

  logic [63:0]         mem_q [MEM_WORDS];

  logic [63:0]         addr_d;
  logic [1:0]          resp_d;
  logic [63:0]         offset;
  logic [63:0]         step;
  logic [63:0]         wrap_mask;
  logic [IDX_W-1:0]    idx;
  logic                dec_err;
  logic                last_beat;
  logic [1:0]          rd_resp;
  logic [1:0]          beat_resp;
  logic                live;
  logic                rd_act;
  logic                wr_en;

  function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    offset    = addr_q - BASE_ADDR;
    dec_err   = (addr_q < BASE_ADDR) || ((offset >> 3) >= 64'(MEM_WORDS));
    idx       = offset[IDX_W+2:3];
    last_beat = (cnt_q == len_q);
    step      = 64'd1 << size_q;
    // WRAP keeps the upper address bits and lets only the in-block bits roll over.
    wrap_mask = ((64'(len_q) + 64'd1) << size_q) - 64'd1;
    case (burst_q)
      2'b01:   addr_d = addr_q + step;
      2'b10:   addr_d = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_d = addr_q;
    endcase
    rd_resp   = dec_err ? 2'b11 : ((burst_q == 2'b11) ? 2'b10 : 2'b00);
    beat_resp = dec_err ? 2'b11 : 2'b00;
    if ((burst_q == 2'b11) || (axi.w_last != last_beat)) begin
      beat_resp = rmax(beat_resp, 2'b10);
    end
    resp_d    = rmax(resp_q, beat_resp);
  end

  always_comb begin
    live         = !reset;
    rd_act       = live && (state_q == RD);
    axi.ar_ready = live && (state_q == IDLE);
    axi.aw_ready = live && (state_q == IDLE) && !axi.ar_valid;
    axi.w_ready  = live && (state_q == WDATA);
    axi.r_valid  = rd_act;
    axi.r_data   = (rd_act && !dec_err) ? mem_q[idx] : '0;
    axi.r_resp   = rd_act ? rd_resp : '0;
    axi.r_last   = rd_act && last_beat;
    axi.r_id     = rd_act ? id_q : '0;
    axi.r_user   = '0;
    axi.b_valid  = live && (state_q == WRESP);
    axi.b_resp   = axi.b_valid ? resp_q : '0;
    axi.b_id     = axi.b_valid ? id_q : '0;
    axi.b_user   = '0;
    wr_en        = live && (state_q == WDATA) && axi.w_valid && !dec_err;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (axi.w_strb[i]) mem_q[idx][8*i +: 8] <= axi.w_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (axi.ar_valid) begin
            addr_q  <= axi.ar_addr;
            id_q    <= axi.ar_id;
            len_q   <= axi.ar_len;
            size_q  <= axi.ar_size;
            burst_q <= axi.ar_burst;
            cnt_q   <= '0;
            resp_q  <= '0;
            state_q <= RD;
          end else if (axi.aw_valid) begin
            addr_q  <= axi.aw_addr;
            id_q    <= axi.aw_id;
            len_q   <= axi.aw_len;
            size_q  <= axi.aw_size;
            burst_q <= axi.aw_burst;
            cnt_q   <= '0;
            resp_q  <= '0;
            state_q <= WDATA;
          end
        end
        RD: begin
          if (axi.r_ready) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_q + 8'd1;
            if (last_beat) state_q <= IDLE;
          end
        end
        WDATA: begin
          if (axi.w_valid) begin
            resp_q <= resp_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_q + 8'd1;
            if (last_beat) state_q <= WRESP;
          end
        end
        WRESP: begin
          if (axi.b_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: stimulus tasks queue expected R/B responses and a
// negedge monitor compares every presented beat against the queue front.
module tb_axi_mem_slave;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_mem_slave_if #(.ID_WIDTH(4), .USER_WIDTH(1)) bus ();

  axi_mem_slave #(
    .ID_WIDTH(4), .USER_WIDTH(1), .BASE_ADDR(64'h8000_0000),
    .MEM_WORDS(4096), .MEM_INIT_FILE("")
  ) dut (
    .clock(clock),
    .reset(reset),
    .axi  (bus)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  int total = 0;
  int bad   = 0;
  logic [63:0] wd [8];
  logic [7:0]  ws [8];

  localparam logic [63:0] A0 = 64'hA0A0A0A0_00000000;
  localparam logic [63:0] B0 = 64'hB0B0B0B0_00000000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: actual=no handshake required=handshake within bound", name);
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
    rq.push_back('{data: d, resp: r, last: l, id: id});
  endtask

  always @(negedge clock) begin
    if (!reset && bus.r_valid) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL r_unexpected: actual data=%h required no beat", bus.r_data);
      end else begin
        chk("r_data", bus.r_data, rq[0].data);
        chk("r_resp", 64'(bus.r_resp), 64'(rq[0].resp));
        chk("r_last", 64'(bus.r_last), 64'(rq[0].last));
        chk("r_id",   64'(bus.r_id),   64'(rq[0].id));
        if (bus.r_ready) void'(rq.pop_front());
      end
    end
    if (!reset && bus.b_valid) begin
      if (bq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected: actual resp=%0d required no response", bus.b_resp);
      end else begin
        chk("b_resp", 64'(bus.b_resp), 64'(bq[0].resp));
        chk("b_id",   64'(bus.b_id),   64'(bq[0].id));
        if (bus.b_ready) void'(bq.pop_front());
      end
    end
  end

  task automatic aw_phase(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic [3:0] id);
    bit ok = 1'b0;
    bus.aw_valid = 1'b1; bus.aw_addr = a; bus.aw_len = l; bus.aw_size = 3'd3;
    bus.aw_burst = b; bus.aw_id = id;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock); ok = bus.aw_ready;
      @(posedge clock); #1;
    end
    bus.aw_valid = 1'b0;
    if (!ok) timeout("aw_wait");
  endtask

  task automatic w_phase(input logic [7:0] l, input bit early);
    bit ok;
    for (int i = 0; i <= int'(l); i++) begin
      ok = 1'b0;
      bus.w_valid = 1'b1; bus.w_data = wd[i]; bus.w_strb = ws[i];
      bus.w_last = early ? (i == 0) : (i == int'(l));
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge clock); ok = bus.w_ready;
        @(posedge clock); #1;
      end
      if (!ok) timeout("w_wait");
    end
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
  endtask

  task automatic b_phase();
    bit ok = 1'b0;
    bus.b_ready = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock); ok = bus.b_valid;
      @(posedge clock); #1;
    end
    bus.b_ready = 1'b0;
    if (!ok) timeout("b_wait");
  endtask

  task automatic do_write1(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           input logic [1:0] resp, input logic [3:0] id);
    wd[0] = d; ws[0] = s;
    bq.push_back('{resp: resp, id: id});
    aw_phase(a, 8'd0, 2'b01, id);
    w_phase(8'd0, 1'b0);
    b_phase();
  endtask

  task automatic do_read(input logic [63:0] a, input logic [7:0] l, input logic [1:0] b,
                         input logic [3:0] id, input bit toggle, input int stop_after);
    bit ok = 1'b0;
    bit done = 1'b0;
    int hs = 0;
    bus.ar_valid = 1'b1; bus.ar_addr = a; bus.ar_len = l; bus.ar_size = 3'd3;
    bus.ar_burst = b; bus.ar_id = id;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock); ok = bus.ar_ready;
      @(posedge clock); #1;
    end
    bus.ar_valid = 1'b0;
    if (!ok) timeout("ar_wait");
    for (int k = 0; k < 100 && !done; k++) begin
      bus.r_ready = toggle ? (k % 2 == 0) : 1'b1;
      @(negedge clock);
      if (k == 0) chk("r_latency", 64'(bus.r_valid), 64'd1);
      if (bus.r_valid && bus.r_ready) begin
        hs++;
        if (bus.r_last || hs == stop_after) done = 1'b1;
      end
      @(posedge clock); #1;
    end
    bus.r_ready = 1'b0;
    if (!done) timeout("r_wait");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.aw_valid = 1'b1; bus.aw_addr = '0; bus.aw_id = '0; bus.aw_len = '0;
    bus.aw_size = '0; bus.aw_burst = '0;
    bus.w_valid = 1'b1; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    bus.ar_valid = 1'b1; bus.ar_addr = '0; bus.ar_id = '0; bus.ar_len = '0;
    bus.ar_size = '0; bus.ar_burst = '0;
    reset = 1'b1;

    // Reset state, with every request valid held high to show the gating.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
    chk("rst_w_ready",  64'(bus.w_ready),  64'd0);
    chk("rst_b_valid",  64'(bus.b_valid),  64'd0);
    chk("rst_r_valid",  64'(bus.r_valid),  64'd0);
    chk("rst_r_data",   bus.r_data,        64'd0);
    chk("rst_r_last",   64'(bus.r_last),   64'd0);
    chk("rst_b_resp",   64'(bus.b_resp),   64'd0);
    @(posedge clock); #1;
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ar_ready", 64'(bus.ar_ready), 64'd1);
    chk("idle_aw_ready", 64'(bus.aw_ready), 64'd1);
    @(posedge clock); #1;

    // Single-beat write then read.
    do_write1(64'h8000_0010, 64'h1122334455667788, 8'hFF, 2'b00, 4'h3);
    push_r(64'h1122334455667788, 2'b00, 1'b1, 4'h5);
    do_read(64'h8000_0010, 8'd0, 2'b01, 4'h5, 1'b0, 0);

    // INCR write of words 0..3, then back-pressured INCR read.
    for (int i = 0; i < 4; i++) begin wd[i] = A0 + 64'(i); ws[i] = 8'hFF; end
    bq.push_back('{resp: 2'b00, id: 4'h2});
    aw_phase(64'h8000_0000, 8'd3, 2'b01, 4'h2);
    w_phase(8'd3, 1'b0);
    b_phase();
    for (int i = 0; i < 4; i++) push_r(A0 + 64'(i), 2'b00, (i == 3), 4'h9);
    do_read(64'h8000_0000, 8'd3, 2'b01, 4'h9, 1'b1, 0);

    // WRAP write starting at word 3 lands on 3,0,1,2.
    for (int i = 0; i < 4; i++) begin wd[i] = B0 + 64'(i); ws[i] = 8'hFF; end
    bq.push_back('{resp: 2'b00, id: 4'hA});
    aw_phase(64'h8000_0018, 8'd3, 2'b10, 4'hA);
    w_phase(8'd3, 1'b0);
    b_phase();
    push_r(B0 + 64'd1, 2'b00, 1'b0, 4'hB);
    push_r(B0 + 64'd2, 2'b00, 1'b0, 4'hB);
    push_r(B0 + 64'd3, 2'b00, 1'b0, 4'hB);
    push_r(B0 + 64'd0, 2'b00, 1'b1, 4'hB);
    do_read(64'h8000_0000, 8'd3, 2'b01, 4'hB, 1'b0, 0);

    // Partial strobe over a zeroed word.
    do_write1(64'h8000_0028, 64'h0, 8'hFF, 2'b00, 4'h1);
    do_write1(64'h8000_0028, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2'b00, 4'h1);
    push_r(64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1, 4'h1);
    do_read(64'h8000_0028, 8'd0, 2'b01, 4'h1, 1'b0, 0);

    // Decode errors: below base must not alias onto the top word; reads return 0/DECERR.
    do_write1(64'h8000_7FF8, 64'hC0FFEE00_DEADBEEF, 8'hFF, 2'b00, 4'h4);
    do_write1(64'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF, 2'b11, 4'h4);
    push_r(64'hC0FFEE00_DEADBEEF, 2'b00, 1'b1, 4'h4);
    do_read(64'h8000_7FF8, 8'd0, 2'b01, 4'h4, 1'b0, 0);
    push_r(64'h0, 2'b11, 1'b1, 4'h4);
    do_read(64'h7FFF_FFF8, 8'd0, 2'b01, 4'h4, 1'b0, 0);
    push_r(64'h0, 2'b11, 1'b1, 4'h4);
    do_read(64'h8000_8000, 8'd0, 2'b01, 4'h4, 1'b0, 0);

    // Reserved burst read: fixed address, SLVERR on every beat.
    push_r(B0 + 64'd1, 2'b10, 1'b0, 4'h4);
    push_r(B0 + 64'd1, 2'b10, 1'b1, 4'h4);
    do_read(64'h8000_0000, 8'd1, 2'b11, 4'h4, 1'b0, 0);

    // Simultaneous AR/AW: read first, AW the cycle after the read completes.
    push_r(B0 + 64'd3, 2'b00, 1'b1, 4'h1);
    bq.push_back('{resp: 2'b10, id: 4'h7});
    bus.ar_valid = 1'b1; bus.ar_addr = 64'h8000_0010; bus.ar_len = 8'd0; bus.ar_size = 3'd3;
    bus.ar_burst = 2'b01; bus.ar_id = 4'h1;
    bus.aw_valid = 1'b1; bus.aw_addr = 64'h8000_0030; bus.aw_len = 8'd1; bus.aw_size = 3'd3;
    bus.aw_burst = 2'b01; bus.aw_id = 4'h7;
    bus.r_ready = 1'b1;
    @(negedge clock);
    chk("both_ar_ready", 64'(bus.ar_ready), 64'd1);
    chk("both_aw_ready", 64'(bus.aw_ready), 64'd0);
    @(posedge clock); #1;
    bus.ar_valid = 1'b0;
    @(negedge clock);
    chk("both_r_valid",  64'(bus.r_valid),  64'd1);
    chk("rd_aw_ready",   64'(bus.aw_ready), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("after_aw_ready", 64'(bus.aw_ready), 64'd1);
    chk("after_r_valid",  64'(bus.r_valid),  64'd0);
    @(posedge clock); #1;
    bus.aw_valid = 1'b0; bus.r_ready = 1'b0;
    wd[0] = 64'hE0E0_0000_0000_0000; wd[1] = 64'hE1E1_0000_0000_0001;
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    w_phase(8'd1, 1'b1);
    b_phase();
    push_r(64'hE0E0_0000_0000_0000, 2'b00, 1'b0, 4'h2);
    push_r(64'hE1E1_0000_0000_0001, 2'b00, 1'b1, 4'h2);
    do_read(64'h8000_0030, 8'd1, 2'b01, 4'h2, 1'b0, 0);

    // Reset after the second beat of a len-7 read.
    push_r(B0 + 64'd1, 2'b00, 1'b0, 4'h6);
    push_r(B0 + 64'd2, 2'b00, 1'b0, 4'h6);
    do_read(64'h8000_0000, 8'd7, 2'b01, 4'h6, 1'b0, 2);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_r_valid",  64'(bus.r_valid),  64'd0);
    chk("mid_rst_ar_ready", 64'(bus.ar_ready), 64'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ar_ready", 64'(bus.ar_ready), 64'd1);
    @(posedge clock); #1;
    push_r(B0 + 64'd0, 2'b00, 1'b1, 4'h8);
    do_read(64'h8000_0018, 8'd0, 2'b01, 4'h8, 1'b0, 0);

    repeat (3) @(posedge clock);
    #1;
    chk("r_queue_left", 64'(rq.size()), 64'd0);
    chk("b_queue_left", 64'(bq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
